// File: rtl/fifo_burst_drain.sv
// Drains the upstream level-reporting FIFO in bursts: one header beat carrying
// the burst length, then the payload beats, the final one flagged with out_last.
module fifo_burst_drain #(
  parameter int PTR_W     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [PTR_W:0]    fifo_level,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hdr,
  output logic              out_last,
  output logic              busy
);

  localparam int LEN_W = $clog2(BURST_MAX + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W:0]     LVL_MAX = (PTR_W+1)'(BURST_MAX);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(BURST_MAX);
  localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
  localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_ONE = TMR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] remain_q, remain_d;

  logic trig_full, trig_part;

  // A full burst's worth of data wins; otherwise a stale or flushed
  // non-empty FIFO forces a partial burst of whatever is stored right now.
  assign trig_full = (fifo_level >= LVL_MAX);
  assign trig_part = !fifo_empty && ((timer_q == TMR_MAX) || flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      len_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    len_d     = len_q;
    remain_d  = remain_q;
    out_valid = 1'b0;
    out_hdr   = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    fifo_pop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig_full) begin
          len_d   = LEN_MAX;
          timer_d = '0;
          state_d = S_HDR;
        end else if (trig_part) begin
          // level < BURST_MAX here, so it fits in len
          len_d   = LEN_W'(fifo_level);
          timer_d = '0;
          state_d = S_HDR;
        end else if (fifo_empty) begin
          timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      S_HDR: begin
        out_valid = 1'b1;
        out_hdr   = 1'b1;
        out_data  = DATA_W'(len_q);
        if (out_ready) begin
          remain_d = len_q;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        out_valid = 1'b1;
        out_data  = fifo_data;
        out_last  = (remain_q == LEN_ONE);
        fifo_pop  = out_ready;
        if (out_ready) begin
          remain_d = remain_q - LEN_ONE;
          if (out_last) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a behavioural 16-deep FIFO upstream, a table of
// burst scenarios with hand-computed headers/latencies, plus reset/flush cases.
module tb_fifo_burst_drain;

  localparam int PTR_W = 4;
  localparam int DATA_W = 8;
  localparam int CYC = 120;
  localparam int NVEC = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [PTR_W:0]    fifo_level;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_hdr;
  logic              out_last;
  logic              busy;

  logic              push;
  logic [DATA_W-1:0] push_data;

  always #5 clk = ~clk;

  fifo_burst_drain #(.PTR_W(PTR_W), .DATA_W(DATA_W), .BURST_MAX(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_hdr(out_hdr), .out_last(out_last), .busy(busy)
  );

  // upstream FIFO model
  logic [DATA_W-1:0] mem [16];
  logic [PTR_W:0]    wp, rp;
  assign fifo_level = wp - rp;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_data  = mem[rp[PTR_W-1:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && fifo_level < 5'd16) begin
        mem[wp[PTR_W-1:0]] <= push_data;
        wp <= wp + 5'd1;
      end
      if (fifo_pop && !fifo_empty) rp <= rp + 5'd1;
    end
  end

  typedef struct packed {
    logic              hdr;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    int          npush;
    logic [7:0]  base;
    bit          flsh;
    int          mode;   // 0: ready high, 1: ready low while pushing, 2: random ready
    int          h0;
    int          h1;
    int          lat;    // edges from first push to header valid
  } vec_t;

  vec_t  vecs [NVEC];
  beat_t rx_q [$];
  beat_t exp_q [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    pop_cnt;
  bit    stall_prev;
  beat_t prev_beat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // one clock: sample/check on the falling edge, return just after the rising edge
  task automatic tick();
    beat_t cur;
    @(negedge clk);
    cur = '{out_hdr, out_last, out_data};
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_beat", 32'(cur), 32'(prev_beat));
    end
    if (out_valid && !out_ready) chk("stall_nopop", 32'(fifo_pop), 32'd0);
    if (fifo_pop) begin
      chk("pop_nonempty", 32'(fifo_empty), 32'd0);
      pop_cnt++;
    end
    if (out_valid && out_ready) rx_q.push_back(cur);
    stall_prev = out_valid && !out_ready;
    prev_beat  = cur;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    int   first, j, h;
    bit   seen;

    vecs[0] = '{8,  8'h10, 1'b0, 0, 8, 0, 8};
    vecs[1] = '{3,  8'hA0, 1'b0, 0, 3, 0, 16};
    vecs[2] = '{2,  8'h30, 1'b1, 0, 2, 0, 2};
    vecs[3] = '{12, 8'h40, 1'b0, 2, 8, 4, 8};
    vecs[4] = '{16, 8'h60, 1'b0, 1, 8, 8, 8};
    vecs[5] = '{1,  8'h77, 1'b1, 0, 1, 0, 1};
    vecs[6] = '{9,  8'h80, 1'b0, 0, 8, 1, 8};

    rst = 1'b1; push = 1'b0; push_data = '0; flush = 1'b0; out_ready = 1'b1;
    stall_prev = 1'b0; prev_beat = '0; pop_cnt = 0;
    #3;
    chk("reset_outputs", {19'd0, out_valid, out_hdr, out_last, fifo_pop, busy, out_data}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      t = vecs[v];
      exp_q.delete();
      rx_q.delete();
      j = 0;
      for (int b = 0; b < 2; b++) begin
        h = (b == 0) ? t.h0 : t.h1;
        if (h > 0) begin
          exp_q.push_back('{1'b1, 1'b0, 8'(h)});
          for (int i = 0; i < h; i++) begin
            exp_q.push_back('{1'b0, (i == h - 1), 8'(t.base + 8'(j))});
            j++;
          end
        end
      end
      pop_cnt = 0;
      first = -1;
      for (int k = 0; k < CYC; k++) begin
        push      = (k < t.npush);
        push_data = 8'(t.base + 8'(k));
        flush     = t.flsh && (k == t.npush);
        case (t.mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (k >= t.npush);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        tick();
        if (first < 0 && out_valid) first = k;
      end
      push = 1'b0; flush = 1'b0; out_ready = 1'b1;
      chk($sformatf("v%0d_hdr_latency", v), 32'(first), 32'(t.lat));
      chk($sformatf("v%0d_beat_count", v), 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
        chk($sformatf("v%0d_beat%0d", v, i), 32'(rx_q[i]), 32'(exp_q[i]));
      chk($sformatf("v%0d_pops", v), 32'(pop_cnt), 32'(t.npush));
      chk($sformatf("v%0d_end_idle", v), {30'd0, fifo_empty, busy}, 32'd2);
    end

    // flush with an empty FIFO must not start anything
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen |= (busy | out_valid);
    end
    chk("flush_empty_ignored", 32'(seen), 32'd0);

    // reset in the middle of a data phase
    rx_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push = 1'b1;
      push_data = 8'(8'hC0 + 8'(k));
      tick();
    end
    push = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = out_valid;
    end
    chk("mid_hdr_valid", {24'd0, out_hdr, out_data[6:0]}, {24'd0, 1'b1, 7'd8});
    out_ready = 1'b1;
    repeat (4) tick();
    chk("mid_data_state", {28'd0, out_valid, fifo_pop, busy, out_hdr}, 32'hE);
    chk("mid_data_head", 32'(out_data), 32'hC3);
    chk("mid_beats_before_rst", 32'(rx_q.size()), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {26'd0, out_valid, fifo_pop, busy, out_hdr, out_last, fifo_empty}, 32'd1);
    stall_prev = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      seen |= (busy | out_valid | fifo_pop);
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    // recovery: one byte plus flush yields a 1-beat burst
    rx_q.delete();
    push = 1'b1; push_data = 8'h5A;
    tick();
    push = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    chk("recover_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("recover_hdr", 32'(rx_q[0]), 32'(beat_t'{1'b1, 1'b0, 8'h01}));
      chk("recover_data", 32'(rx_q[1]), 32'(beat_t'{1'b0, 1'b1, 8'h5A}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
